// File: rtl/pipeline_run_ctrl.sv
// Run controller and hazard sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Conditions the start button, sequences IDLE/RUN/DRAIN/HALTED and issues stalls/flushes.
module pipeline_run_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter int         DRAIN_CYCLES    = 4,
   parameter logic [4:0] HALT_OPCODE     = 5'b11111,
   parameter int         CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_button,
   input  logic             image_select,
   input  logic [31:0]      instr_id,
   input  logic             id_valid,
   input  logic             branch_taken_ex,
   input  logic             load_ex,
   input  logic [4:0]       rd_ex,
   output logic             cpu_rst,
   output logic             stall,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             running,
   output logic             halted,
   output logic             image_sel_q,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       dbg_state
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_btn_sync;
   logic [1:0]       r_img_sync;
   logic [DB_W-1:0]  r_db_cnt;
   logic             r_db_level;
   logic             r_db_prev;
   logic [DR_W-1:0]  r_drain_cnt;
   logic             r_cpu_rst;
   logic             r_running;
   logic             r_halted;
   logic             r_image_sel;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_start_evt;
   logic w_load_use;
   logic w_halt;
   logic w_in_run;
   logic w_parked;
   logic w_lu_stall;
   logic w_unused;

   // Button path: 2-flop synchronizer, then a level debouncer with edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_sync <= '0;
         r_img_sync <= '0;
         r_db_cnt   <= '0;
         r_db_level <= 1'b0;
         r_db_prev  <= 1'b0;
      end else begin
         r_btn_sync <= {r_btn_sync[0], start_button};
         r_img_sync <= {r_img_sync[0], image_select};
         r_db_prev  <= r_db_level;
         if (r_btn_sync[1] != r_db_level) begin
            if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_db_level <= r_btn_sync[1];
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + DB_W'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   assign w_start_evt = r_db_level & ~r_db_prev;

   assign w_load_use = load_ex & id_valid & (rd_ex != 5'd0) &
                       ((rd_ex == instr_id[21:17]) | (rd_ex == instr_id[16:12]));
   assign w_halt     = id_valid & (instr_id[31:27] == HALT_OPCODE) & ~branch_taken_ex;
   assign w_in_run   = (r_state == S_RUN);
   assign w_parked   = (r_state == S_DRAIN) | (r_state == S_HALTED);
   // A taken branch squashes the consumer anyway, so it wins over load-use.
   assign w_lu_stall = w_in_run & w_load_use & ~branch_taken_ex;
   assign w_unused   = ^{instr_id[26:22], instr_id[11:0]};

   assign stall       = w_parked | w_lu_stall;
   assign flush_id_ex = w_parked | (w_in_run & (w_load_use | branch_taken_ex));
   assign flush_if_id = w_in_run & branch_taken_ex;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= '0;
         r_cpu_rst   <= 1'b1;
         r_running   <= 1'b0;
         r_halted    <= 1'b0;
         r_image_sel <= 1'b0;
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_evt) begin
                  r_state     <= S_RUN;
                  r_cpu_rst   <= 1'b0;
                  r_running   <= 1'b1;
                  r_image_sel <= r_img_sync[1];
                  r_cycle_cnt <= '0;
                  r_stall_cnt <= '0;
               end
            end
            S_RUN: begin
               if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
               if (w_lu_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
               if (w_halt) begin
                  r_state     <= S_DRAIN;
                  r_running   <= 1'b0;
                  r_drain_cnt <= DR_W'(DRAIN_CYCLES - 1);
               end
            end
            S_DRAIN: begin
               if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
               if (r_drain_cnt == '0) begin
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - DR_W'(1);
               end
            end
            S_HALTED: begin
               if (w_start_evt) begin
                  r_state   <= S_IDLE;
                  r_halted  <= 1'b0;
                  r_cpu_rst <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_cpu_rst <= 1'b1;
               r_running <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_rst     = r_cpu_rst;
   assign running     = r_running;
   assign halted      = r_halted;
   assign image_sel_q = r_image_sel;
   assign cycle_count = r_cycle_cnt;
   assign stall_count = r_stall_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: start/debounce, hazards, HALT drain, restart, reset.
module tb_pipeline_run_ctrl;

   localparam logic [4:0] HALT_OP = 5'b11111;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_button;
   logic        image_select;
   logic [31:0] instr_id;
   logic        id_valid;
   logic        branch_taken_ex;
   logic        load_ex;
   logic [4:0]  rd_ex;
   logic        cpu_rst;
   logic        stall;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        running;
   logic        halted;
   logic        image_sel_q;
   logic [31:0] cycle_count;
   logic [31:0] stall_count;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_cyc;

   pipeline_run_ctrl #(
      .DEBOUNCE_CYCLES(16),
      .DRAIN_CYCLES   (4),
      .HALT_OPCODE    (HALT_OP),
      .CNT_W          (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_button   (start_button),
      .image_select   (image_select),
      .instr_id       (instr_id),
      .id_valid       (id_valid),
      .branch_taken_ex(branch_taken_ex),
      .load_ex        (load_ex),
      .rd_ex          (rd_ex),
      .cpu_rst        (cpu_rst),
      .stall          (stall),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .running        (running),
      .halted         (halted),
      .image_sel_q    (image_sel_q),
      .cycle_count    (cycle_count),
      .stall_count    (stall_count),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges taken while the controller should be in RUN or DRAIN.
   task automatic run_tick(input int n);
      repeat (n) begin
         tick(1);
         exp_cyc++;
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {op, 5'd3, rs1, rs2, 12'h0};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start_button = 1'b0; image_select = 1'b0; instr_id = '0;
      id_valid = 1'b0; branch_taken_ex = 1'b0; load_ex = 1'b0; rd_ex = '0;
      exp_cyc = '0;
      #3;
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_running", running, 0);
      check("rst_halted", halted, 0);
      check("rst_stall", stall, 0);
      check("rst_flush_idex", flush_id_ex, 0);
      check("rst_img", image_sel_q, 0);
      check("rst_cycles", cycle_count, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Hazard inputs have no effect while IDLE.
      load_ex = 1'b1; rd_ex = 5'd7; instr_id = mk(5'd0, 5'd1, 5'd7); id_valid = 1'b1;
      branch_taken_ex = 1'b1;
      #1;
      check("idle_stall", stall, 0);
      check("idle_flush_idex", flush_id_ex, 0);
      check("idle_flush_ifid", flush_if_id, 0);
      load_ex = 1'b0; branch_taken_ex = 1'b0; id_valid = 1'b0;

      // Clean press: 2 sync + 16 debounce edges, FSM moves on the next edge.
      start_button = 1'b1; image_select = 1'b1;
      tick(18);
      check("press_not_yet", running, 0);
      check("press_rst_held", cpu_rst, 1);
      tick(1);
      check("start_running", running, 1);
      check("start_cpu_rst", cpu_rst, 0);
      check("start_img", image_sel_q, 1);
      check("start_cycles", cycle_count, 0);
      exp_cyc = 0;
      for (int k = 1; k <= 3; k++) begin
         run_tick(1);
         check("cycle_inc", cycle_count, exp_cyc);
      end
      run_tick(8);
      start_button = 1'b0;
      run_tick(20);
      check("cycle_long", cycle_count, exp_cyc);

      // Load-use via rs2.
      load_ex = 1'b1; rd_ex = 5'd7; instr_id = mk(5'd0, 5'd1, 5'd7); id_valid = 1'b1;
      #1;
      check("lu_rs2_stall", stall, 1);
      check("lu_rs2_flush_idex", flush_id_ex, 1);
      check("lu_rs2_flush_ifid", flush_if_id, 0);
      run_tick(1);
      load_ex = 1'b0;
      #1;
      check("lu_after_stall", stall, 0);
      check("lu_rs2_count", stall_count, 1);

      // rd_ex = x0 never creates a hazard.
      load_ex = 1'b1; rd_ex = 5'd0; instr_id = mk(5'd0, 5'd0, 5'd0);
      #1;
      check("lu_x0_stall", stall, 0);
      check("lu_x0_flush", flush_id_ex, 0);
      run_tick(1);
      check("lu_x0_count", stall_count, 1);

      // Load-use via rs1.
      rd_ex = 5'd5; instr_id = mk(5'd0, 5'd5, 5'd9);
      #1;
      check("lu_rs1_stall", stall, 1);
      run_tick(1);
      load_ex = 1'b0;
      check("lu_rs1_count", stall_count, 2);

      // Branch together with load-use: flush both, no stall.
      load_ex = 1'b1; rd_ex = 5'd7; instr_id = mk(5'd0, 5'd1, 5'd7); branch_taken_ex = 1'b1;
      #1;
      check("br_flush_ifid", flush_if_id, 1);
      check("br_flush_idex", flush_id_ex, 1);
      check("br_stall", stall, 0);
      run_tick(1);
      load_ex = 1'b0; branch_taken_ex = 1'b0;
      check("br_stall_count", stall_count, 2);

      // HALT under a taken branch is squashed.
      instr_id = mk(HALT_OP, 5'd0, 5'd0); id_valid = 1'b1; branch_taken_ex = 1'b1;
      run_tick(1);
      branch_taken_ex = 1'b0; id_valid = 1'b0;
      check("halt_squash_run", running, 1);
      check("halt_squash_halted", halted, 0);

      // HALT drains for 4 cycles, then parks.
      id_valid = 1'b1;
      run_tick(1);
      #1;
      check("drain_running", running, 0);
      check("drain_stall", stall, 1);
      check("drain_flush_idex", flush_id_ex, 1);
      check("drain_flush_ifid", flush_if_id, 0);
      run_tick(3);
      check("drain_not_halted", halted, 0);
      run_tick(1);
      check("halted_set", halted, 1);
      check("halted_cycles", cycle_count, exp_cyc);
      id_valid = 1'b0;
      tick(3);
      check("halted_frozen", cycle_count, exp_cyc);
      check("halted_stall", stall, 1);
      check("halted_flush_idex", flush_id_ex, 1);
      check("halted_cpu_rst", cpu_rst, 0);
      check("halted_stall_count", stall_count, 2);

      // Press in HALTED returns to IDLE, keeping image_sel_q.
      start_button = 1'b1; image_select = 1'b0;
      tick(18);
      check("restart_wait", halted, 1);
      tick(1);
      check("restart_halted", halted, 0);
      check("restart_cpu_rst", cpu_rst, 1);
      check("restart_running", running, 0);
      check("restart_img", image_sel_q, 1);
      check("restart_stall", stall, 0);
      tick(1);
      check("idle_hold_cpu_rst", cpu_rst, 1);
      check("idle_hold_running", running, 0);
      tick(10);
      start_button = 1'b0;
      tick(20);
      check("idle_after_release", running, 0);

      // Bouncing button every 5 cycles never debounces.
      for (int i = 0; i < 20; i++) begin
         start_button = ~start_button;
         tick(5);
      end
      tick(20);
      check("bounce_running", running, 0);
      check("bounce_cpu_rst", cpu_rst, 1);

      // Second press starts a fresh run with cleared counters.
      start_button = 1'b1;
      tick(19);
      check("run2_running", running, 1);
      check("run2_img", image_sel_q, 0);
      check("run2_cycles", cycle_count, 0);
      check("run2_stalls", stall_count, 0);
      exp_cyc = 0;
      run_tick(2);
      check("run2_cycle_inc", cycle_count, exp_cyc);
      start_button = 1'b0;

      // Reset asserted mid-drain returns to IDLE immediately.
      instr_id = mk(HALT_OP, 5'd0, 5'd0); id_valid = 1'b1;
      run_tick(1);
      id_valid = 1'b0;
      tick(2);
      check("pre_rst_drain_stall", stall, 1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_cpu_rst", cpu_rst, 1);
      check("midrst_stall", stall, 0);
      check("midrst_flush_idex", flush_id_ex, 0);
      check("midrst_running", running, 0);
      check("midrst_halted", halted, 0);
      check("midrst_cycles", cycle_count, 0);
      check("midrst_stalls", stall_count, 0);
      check("midrst_img", image_sel_q, 0);
      tick(1);
      rst = 1'b0;
      tick(2);
      check("post_rst_idle", cpu_rst, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Run controller and hazard sequencer for the 5-stage scalar/vector CPU pipeline (IF/ID/EX/MEM/WB).
- Converts the raw start button into a clean start event.
- Holds the pipeline in reset until started, then runs it.
- Detects the HALT instruction in ID and drains the pipeline before parking.
- Generates load-use stalls and taken-branch flushes for the pipeline registers.
- Keeps cycle and stall performance counters.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (>=2)
DRAIN_CYCLES, 4, bubble cycles inserted after HALT before parking (covers EX/MEM/WB; >=1)
HALT_OPCODE, 5'b11111, value of instr_id[31:27] that encodes HALT
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_button  in  1  raw, asynchronous, active-high pushbutton
image_select  in  1  raw image-select switch, sampled at start
instr_id  in  32  instruction in ID; opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12]
id_valid  in  1  ID holds a real instruction, not a bubble
branch_taken_ex  in  1  EX resolved a taken branch or jump this cycle
load_ex  in  1  EX holds a scalar or vector memory load
rd_ex  in  5  destination register of the instruction in EX
cpu_rst  out  1  synchronous reset to PC and pipeline registers
stall  out  1  freeze PC and IF/ID register
flush_if_id  out  1  clear IF/ID to a bubble
flush_id_ex  out  1  clear ID/EX to a bubble
running  out  1  FSM is in RUN
halted  out  1  FSM is in HALTED
image_sel_q  out  1  image_select latched at the accepted start event
cycle_count  out  CNT_W  cycles spent in RUN plus DRAIN
stall_count  out  CNT_W  load-use stall cycles

Behaviour:
- Reset (rst high, async): FSM=IDLE, cpu_rst=1, all other outputs 0, counters 0, synchronizer/debounce flops 0.
- Button conditioning:
  - 2-flop synchronizer feeds a debounce counter.
  - The debounced level toggles only after DEBOUNCE_CYCLES consecutive equal samples that differ from it.
  - start_evt = 1-cycle pulse on the debounced rising edge.
  - Latency from a stable press to start_evt: 2+DEBOUNCE_CYCLES cycles.
- FSM states:
  - IDLE: cpu_rst=1. On start_evt: latch image_sel_q <= synchronized image_select, clear both counters, go to RUN. cpu_rst drops on the next cycle.
  - RUN: cpu_rst=0; hazard logic is active.
    - HALT condition: id_valid & instr_id[31:27]==HALT_OPCODE & !branch_taken_ex.
    - On HALT: go to DRAIN and load drain counter with DRAIN_CYCLES-1.
    - A HALT under a taken branch is squashed and ignored.
  - DRAIN: stall=1 and flush_id_ex=1 every cycle, so HALT stays in ID and only bubbles advance. Counter decrements; at 0, go to HALTED.
  - HALTED: stall=1, flush_id_ex=1, cpu_rst=0, halted=1. Counters are frozen and readable. On start_evt: go to IDLE, which gives 1 reset cycle, then needs another start_evt. image_sel_q is unchanged until that next start.
  - start_evt in RUN or DRAIN is ignored.
- Hazards (RUN only, combinational from inputs):
  - load-use = load_ex & id_valid & rd_ex!=0 & (rd_ex==instr_id[21:17] | rd_ex==instr_id[16:12]).
  - On load-use: stall=1 and flush_id_ex=1 for exactly that cycle. The next cycle the load is in MEM, so load-use cannot recur for the same pair.
  - On branch_taken_ex: flush_if_id=1 and flush_id_ex=1, stall=0.
  - Branch has priority over load-use. When both occur, no stall is issued and stall_count does not increment.
  - Both hazard outputs are 0 outside RUN, except for the DRAIN/HALTED forcing above.
- Counters:
  - cycle_count increments every RUN and DRAIN cycle.
  - stall_count increments every load-use stall cycle.
  - Both saturate at all-ones; no wrap.
  - Both clear only on start in IDLE or on rst.
- rst asserted mid-RUN or mid-DRAIN: immediate return to IDLE; the in-flight drain is abandoned.

Test Plan:
- Reset then press start for 30 cycles with image_select=1 → start_evt 18 cycles after the press; cpu_rst 1→0; running=1; image_sel_q=1; cycle_count counts 1,2,3…
- Button bouncing 0/1 every 5 cycles for 100 cycles with DEBOUNCE_CYCLES=16 → no start_evt; FSM stays IDLE.
- RUN with load_ex=1, rd_ex=7, instr_id rs2=7, id_valid=1 → stall=1 and flush_id_ex=1 for one cycle; stall_count=1. Repeat with rd_ex=0 → no stall.
- Same cycle has branch_taken_ex=1 and a load-use match → flush_if_id=flush_id_ex=1, stall=0, stall_count unchanged.
- HALT opcode in ID with DRAIN_CYCLES=4 → 4 DRAIN cycles with stall=1, then halted=1 and cycle_count frozen. HALT together with branch_taken_ex=1 → stays in RUN.
- In HALTED, press start → 1 IDLE cycle with cpu_rst=1; a second press → RUN with counters cleared. Assert rst during DRAIN → IDLE immediately, all outputs at reset values.
